fft4_stream: RTL

FFT4_STREAM -- requirements
Module: fft4_stream

---
 rtl/fft4_stream.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fft4_stream.sv
// Streaming 4-point FFT/IFFT: frames of four complex samples pass a collector,
// two butterfly stages and a scaled/saturated output buffer, one sample per cycle.
module fft4_stream #(
    parameter int DW    = 16,
    parameter int SCALE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic                 inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic [1:0]           out_idx,
    output logic                 out_ovf
);

    localparam int W1 = DW + 1;
    localparam int W2 = DW + 2;
    localparam int W3 = DW + 3;

    localparam logic signed [W3-1:0] TWO  = W3'(2);
    localparam logic signed [W3-1:0] MAXV = {4'b0000, {(DW-1){1'b1}}};
    localparam logic signed [W3-1:0] MINV = ~MAXV;

    function automatic logic signed [W1-1:0] ext1(input logic signed [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    function automatic logic signed [W2-1:0] ext2(input logic signed [W1-1:0] v);
        return {v[W1-1], v};
    endfunction

    // Round-half-up divide by 4 when scaling, otherwise pass through widened.
    function automatic logic signed [W3-1:0] round_x(input logic signed [W2-1:0] x);
        logic signed [W3-1:0] t;
        t = {x[W2-1], x};
        if (SCALE != 0) begin
            t = (t + TWO) >>> 2;
        end
        return t;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [DW:0] sat_dw(input logic signed [W3-1:0] t);
        if (t > MAXV) begin
            return {1'b1, MAXV[DW-1:0]};
        end else if (t < MINV) begin
            return {1'b1, MINV[DW-1:0]};
        end
        return {1'b0, t[DW-1:0]};
    endfunction

    logic [1:0]           cnt_p0;
    logic                 vld_p0, vld_p1, vld_p2;
    logic signed [DW-1:0] re_p0 [4];
    logic signed [DW-1:0] im_p0 [4];
    logic                 inv_p0;

    logic signed [W1-1:0] a_re_p1, a_im_p1, b_re_p1, b_im_p1;
    logic signed [W1-1:0] c_re_p1, c_im_p1, d_re_p1, d_im_p1;
    logic                 inv_p1;

    logic signed [W2-1:0] x_re_p2 [4];
    logic signed [W2-1:0] x_im_p2 [4];

    logic signed [DW-1:0] re_p3 [4];
    logic signed [DW-1:0] im_p3 [4];
    logic [3:0]           ovf_p3;

    logic [DW:0]          sat_re [4];
    logic [DW:0]          sat_im [4];

    logic ob_free, mv_p0, mv_p1, mv_p2, accept;

    // A stage advances when the slot below is empty or empties on this edge.
    assign ob_free  = !out_valid || (out_ready && out_idx == 2'd3);
    assign mv_p2    = vld_p2 && ob_free;
    assign mv_p1    = vld_p1 && (!vld_p2 || mv_p2);
    assign mv_p0    = vld_p0 && (!vld_p1 || mv_p1);
    assign in_ready = rst || !vld_p0 || mv_p0;
    assign accept   = in_valid && in_ready && !rst;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sat_re[k] = sat_dw(round_x(x_re_p2[k]));
            sat_im[k] = sat_dw(round_x(x_im_p2[k]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0    <= 2'd0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= 2'd0;
            out_ovf   <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                cnt_p0 <= cnt_p0 + 2'd1;
            end
            vld_p0 <= (vld_p0 && !mv_p0) || (accept && cnt_p0 == 2'd3);
            vld_p1 <= mv_p0 || (vld_p1 && !mv_p1);
            vld_p2 <= mv_p1 || (vld_p2 && !mv_p2);
            if (mv_p2) begin
                out_valid <= 1'b1;
                out_idx   <= 2'd0;
                out_re    <= sat_re[0][DW-1:0];
                out_im    <= sat_im[0][DW-1:0];
                out_ovf   <= sat_re[0][DW] | sat_im[0][DW];
            end else if (out_valid && out_ready) begin
                out_valid <= (out_idx != 2'd3);
                out_idx   <= out_idx + 2'd1;
                out_re    <= re_p3[out_idx + 2'd1];
                out_im    <= im_p3[out_idx + 2'd1];
                out_ovf   <= ovf_p3[out_idx + 2'd1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            // p0: collector
            if (accept) begin
                re_p0[cnt_p0] <= in_re;
                im_p0[cnt_p0] <= in_im;
                if (cnt_p0 == 2'd0) begin
                    inv_p0 <= inv;
                end
            end
            // p1: first butterfly
            if (mv_p0) begin
                a_re_p1 <= ext1(re_p0[0]) + ext1(re_p0[2]);
                a_im_p1 <= ext1(im_p0[0]) + ext1(im_p0[2]);
                b_re_p1 <= ext1(re_p0[0]) - ext1(re_p0[2]);
                b_im_p1 <= ext1(im_p0[0]) - ext1(im_p0[2]);
                c_re_p1 <= ext1(re_p0[1]) + ext1(re_p0[3]);
                c_im_p1 <= ext1(im_p0[1]) + ext1(im_p0[3]);
                d_re_p1 <= ext1(re_p0[1]) - ext1(re_p0[3]);
                d_im_p1 <= ext1(im_p0[1]) - ext1(im_p0[3]);
                inv_p1  <= inv_p0;
            end
            // p2: second butterfly; -jD = (D_im, -D_re), +jD = (-D_im, D_re)
            if (mv_p1) begin
                x_re_p2[0] <= ext2(a_re_p1) + ext2(c_re_p1);
                x_im_p2[0] <= ext2(a_im_p1) + ext2(c_im_p1);
                x_re_p2[2] <= ext2(a_re_p1) - ext2(c_re_p1);
                x_im_p2[2] <= ext2(a_im_p1) - ext2(c_im_p1);
                if (!inv_p1) begin
                    x_re_p2[1] <= ext2(b_re_p1) + ext2(d_im_p1);
                    x_im_p2[1] <= ext2(b_im_p1) - ext2(d_re_p1);
                    x_re_p2[3] <= ext2(b_re_p1) - ext2(d_im_p1);
                    x_im_p2[3] <= ext2(b_im_p1) + ext2(d_re_p1);
                end else begin
                    x_re_p2[1] <= ext2(b_re_p1) - ext2(d_im_p1);
                    x_im_p2[1] <= ext2(b_im_p1) + ext2(d_re_p1);
                    x_re_p2[3] <= ext2(b_re_p1) + ext2(d_im_p1);
                    x_im_p2[3] <= ext2(b_im_p1) - ext2(d_re_p1);
                end
            end
            // p3: output buffer, already scaled and saturated
            if (mv_p2) begin
                for (int k = 0; k < 4; k++) begin
                    re_p3[k]  <= sat_re[k][DW-1:0];
                    im_p3[k]  <= sat_im[k][DW-1:0];
                    ovf_p3[k] <= sat_re[k][DW] | sat_im[k][DW];
                end
            end
        end
    end

endmodule
